neighbor_stream_unpacker: RTL

//  Edge-PE-side receiver for the neighbor-bank stream (valid/sos/eos/data/PE_tag/Neighbor_num_Iter).

---
 rtl/neighbor_stream_unpacker_if.sv | 29 ++
 rtl/neighbor_stream_unpacker.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/neighbor_stream_unpacker_if.sv
// Stream and ID-port bundle for the neighbor stream unpacker.
// master: neighbor-bank side and edge-PE consumer; slave: the unpacker itself.
interface neighbor_stream_unpacker_if #(
  parameter int ID_W         = 7,
  parameter int IDS_PER_BEAT = 2,
  parameter int CNT_W        = 5,
  parameter int TAG_W        = 2
);
  logic                         in_valid;
  logic                         in_sos;
  logic                         in_eos;
  logic [ID_W*IDS_PER_BEAT-1:0] in_data;
  logic [TAG_W-1:0]             in_pe_tag;
  logic [CNT_W-1:0]             in_num_iter;
  logic                         out_valid;
  logic                         out_ready;
  logic [ID_W-1:0]              out_id;
  logic                         out_last;

  modport master (
    output in_valid, in_sos, in_eos, in_data, in_pe_tag, in_num_iter, out_ready,
    input  out_valid, out_id, out_last
  );

  modport slave (
    input  in_valid, in_sos, in_eos, in_data, in_pe_tag, in_num_iter, out_ready,
    output out_valid, out_id, out_last
  );
endinterface

// File: rtl/neighbor_stream_unpacker.sv
// Edge-PE receiver: filters neighbor-bank beats by PE tag, buffers them in a
// small beat FIFO (the stream cannot be stalled) and serializes the packed
// neighbor IDs one per cycle onto a valid/ready port, flagging list ends.
module neighbor_stream_unpacker #(
  parameter int ID_W         = 7,
  parameter int IDS_PER_BEAT = 2,
  parameter int CNT_W        = 5,
  parameter int TAG_W        = 2,
  parameter int PE_ID        = 0,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  neighbor_stream_unpacker_if.slave  bus,
  output logic                       almost_full,
  output logic                       list_done,
  output logic                       proto_err,
  output logic                       overflow
);

  localparam int DATA_W  = ID_W * IDS_PER_BEAT;
  localparam int N_W     = $clog2(IDS_PER_BEAT + 1);
  localparam int LANE_W  = (IDS_PER_BEAT > 1) ? $clog2(IDS_PER_BEAT) : 1;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int OCC_W   = PTR_W + 1;
  localparam int ENTRY_W = DATA_W + N_W + 1;

  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);
  localparam logic [OCC_W-1:0] OCC_AF   = OCC_W'(FIFO_DEPTH - 1);
  localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);

  typedef enum logic {S_IDLE, S_EMIT} state_t;

  // ---------------- input side state ----------------
  logic             in_list_reg;
  logic [CNT_W-1:0] total_reg;
  logic [CNT_W-1:0] rcvd_reg;
  logic             proto_err_reg;
  logic             overflow_reg;

  // ---------------- beat FIFO ----------------
  // The occupancy includes the beat currently being serialized: its slot is
  // only released once its last ID has been handed over.
  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [OCC_W-1:0]   occ_reg;

  // ---------------- serializer ----------------
  state_t             state_reg, state_next;
  logic [LANE_W-1:0]  lane_reg, lane_next;
  logic [DATA_W-1:0]  hold_data_reg;
  logic [N_W-1:0]     hold_n_reg;
  logic               hold_last_reg;
  logic [ID_W-1:0]    lane_ids [IDS_PER_BEAT];

  // Combinational helpers
  logic             accept;
  logic             beat_ok;
  logic             restart;
  logic             orphan;
  logic [CNT_W-1:0] total_eff;
  logic [CNT_W-1:0] rcvd_eff;
  logic [CNT_W-1:0] remain;
  logic [N_W-1:0]   n_beat;
  logic             fifo_full;
  logic             push;
  logic             drop;
  logic             pop;
  logic             load;
  logic [PTR_W-1:0] load_ptr;
  logic             finish;
  logic             is_last_lane;
  logic             emit_valid;

  // Split the held beat into its ID lanes (lane 0 in the low bits).
  genvar gi;
  generate
    for (gi = 0; gi < IDS_PER_BEAT; gi++) begin : g_lane
      assign lane_ids[gi] = hold_data_reg[gi*ID_W +: ID_W];
    end
  endgenerate

  // Beat acceptance, list bookkeeping and per-beat ID count.
  always_comb begin
    accept    = bus.in_valid && (bus.in_pe_tag == TAG_W'(PE_ID));
    beat_ok   = accept && (bus.in_sos || in_list_reg);
    restart   = accept && bus.in_sos && in_list_reg;
    orphan    = accept && !bus.in_sos && !in_list_reg;
    total_eff = bus.in_sos ? bus.in_num_iter : total_reg;
    rcvd_eff  = bus.in_sos ? '0 : rcvd_reg;
    remain    = (total_eff > rcvd_eff) ? (total_eff - rcvd_eff) : '0;
    n_beat    = (remain > CNT_W'(IDS_PER_BEAT)) ? N_W'(IDS_PER_BEAT) : remain[N_W-1:0];
    fifo_full = (occ_reg == OCC_FULL);
    // A pop on the same edge frees a slot for the incoming beat.
    push      = beat_ok && (!fifo_full || pop);
    drop      = beat_ok && fifo_full && !pop;
  end

  // List tracking and sticky error flags; counters advance even for dropped beats.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_list_reg   <= 1'b0;
      total_reg     <= '0;
      rcvd_reg      <= '0;
      proto_err_reg <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      if (accept && bus.in_sos) begin
        total_reg <= bus.in_num_iter;
      end
      if (beat_ok) begin
        rcvd_reg    <= rcvd_eff + CNT_W'(n_beat);
        in_list_reg <= !bus.in_eos;
      end
      if (restart || orphan) begin
        proto_err_reg <= 1'b1;
      end
      if (drop) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  // Beat storage write port (no reset needed: occupancy guards every read).
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {bus.in_data, n_beat, bus.in_eos};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      occ_reg    <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      occ_reg <= occ_reg + OCC_W'(push) - OCC_W'(pop);
    end
  end

  // Serializer next state: load the head beat, step through its lanes, and
  // chain straight into the next queued beat when the current one finishes.
  always_comb begin
    state_next   = state_reg;
    lane_next    = lane_reg;
    pop          = 1'b0;
    load         = 1'b0;
    load_ptr     = rd_ptr_reg;
    finish       = 1'b0;
    emit_valid   = 1'b0;
    is_last_lane = (N_W'(lane_reg) == (hold_n_reg - N_W'(1)));
    case (state_reg)
      S_IDLE: begin
        if (occ_reg != '0) begin
          load       = 1'b1;
          lane_next  = '0;
          state_next = S_EMIT;
        end
      end
      S_EMIT: begin
        if (hold_n_reg == '0) begin
          // Empty beat (list ran out of IDs): nothing to emit, retire it.
          finish = 1'b1;
        end else begin
          emit_valid = 1'b1;
          if (bus.out_ready) begin
            if (is_last_lane) begin
              finish = 1'b1;
            end else begin
              lane_next = lane_reg + LANE_W'(1);
            end
          end
        end
        if (finish) begin
          pop       = 1'b1;
          lane_next = '0;
          if (occ_reg > OCC_ONE) begin
            load     = 1'b1;
            load_ptr = rd_ptr_reg + PTR_W'(1);
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Serializer state, lane counter and holding register (registered FIFO read).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      lane_reg      <= '0;
      hold_data_reg <= '0;
      hold_n_reg    <= '0;
      hold_last_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      lane_reg  <= lane_next;
      if (load) begin
        {hold_data_reg, hold_n_reg, hold_last_reg} <= mem[load_ptr];
      end
    end
  end

  assign bus.out_valid = emit_valid;
  assign bus.out_id    = emit_valid ? lane_ids[lane_reg] : '0;
  assign bus.out_last  = emit_valid && hold_last_reg && is_last_lane;
  assign list_done     = finish && hold_last_reg;
  assign almost_full   = (occ_reg >= OCC_AF);
  assign proto_err     = proto_err_reg;
  assign overflow      = overflow_reg;

endmodule
